// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the exec_sequencer control unit.
//   - seq_state_e : sequencer FSM states (StStepWait only when SEQ_STEP_EN is defined)
//   - alu_op_e    : 2-bit ALU function select
//   - instruction field positions, HALT opcode, default ROM depth
package seq_pkg;

    localparam int unsigned IMEM_DEPTH_DEFAULT = 64;

    localparam logic [7:0] HALT_OPCODE = 8'hFF;

    // Instruction layout: [7:6] rd, [5:4] rs1, [3:2] rs2, [1:0] alu_op
    localparam int unsigned FIELD_W = 2;
    localparam int unsigned RD_LSB  = 6;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_LSB = 2;
    localparam int unsigned OP_LSB  = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StDone
`ifdef SEQ_STEP_EN
        ,
        StStepWait
`endif
    } seq_state_e;

    typedef enum logic [1:0] {
        AluAdd = 2'd0,
        AluSub = 2'd1,
        AluAnd = 2'd2,
        AluOr  = 2'd3
    } alu_op_e;

endpackage

// File: rtl/seq_pc.sv
// seq_pc: program counter for exec_sequencer.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset (pc -> 0)
//   i_clr    : synchronous clear to 0 (wins over i_inc)
//   i_inc    : advance by one, wrapping modulo IMEM_DEPTH
//   o_pc     : current program counter
module seq_pc #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned PC_WIDTH   = $clog2(IMEM_DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_clr,
    input  logic                i_inc,
    output logic [PC_WIDTH-1:0] o_pc
);

    // Explicit wrap so non-power-of-two depths still cycle through 0..IMEM_DEPTH-1
    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(IMEM_DEPTH - 1);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        if (i_clr) begin
            w_pc_next = '0;
        end else if (i_inc) begin
            w_pc_next = (r_pc == LAST_PC) ? '0 : r_pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: four-cycle (fetch/decode/execute/writeback) control unit for the
// 16-bit accumulator datapath. Fetches 8-bit instructions from a combinational ROM,
// drives register-file selects and ALU op, and is the sole source of rf_we.
//   clk, reset_n            : clock, asynchronous active-low reset
//   start                   : begin a run at address 0 (sampled only in idle)
//   step                    : single-step release (only when SEQ_STEP_EN is defined)
//   busy, done              : run in progress / one-cycle completion pulse
//   imem_addr, imem_data    : ROM address (== pc) and read data
//   rf_rd/rs1/rs2_sel       : register selects, rf_we : write strobe
//   alu_op                  : ALU function select
//   instr_count             : instructions retired in the current/last run
// Optional feature macro: SEQ_STEP_EN (adds step port and StStepWait state).
module exec_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter int unsigned PC_WIDTH   = $clog2(IMEM_DEPTH),
    parameter int unsigned PROG_LEN   = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
`ifdef SEQ_STEP_EN
    input  logic                step,
`endif
    output logic                busy,
    output logic                done,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [7:0]          imem_data,
    output logic [1:0]          rf_rd_sel,
    output logic [1:0]          rf_rs1_sel,
    output logic [1:0]          rf_rs2_sel,
    output logic                rf_we,
    output logic [1:0]          alu_op,
    output logic [PC_WIDTH:0]   instr_count
);

    localparam logic [PC_WIDTH:0] PROG_LEN_C = (PC_WIDTH + 1)'(PROG_LEN);

    seq_state_e          r_state;
    seq_state_e          w_state_next;
    logic [7:0]          r_ir;
    logic [PC_WIDTH:0]   r_count;
    logic [PC_WIDTH:0]   w_count_inc;
    logic                w_pc_clr;
    logic                w_pc_inc;
    logic                w_ir_load;
    logic                w_retire;
    logic                w_drive;
    logic                w_we;
    alu_op_e             w_alu_op;

    assign w_count_inc = r_count + 1'b1;
    assign w_alu_op    = alu_op_e'(r_ir[OP_LSB +: FIELD_W]);

    always_comb begin
        w_state_next = r_state;
        w_pc_clr     = 1'b0;
        w_pc_inc     = 1'b0;
        w_ir_load    = 1'b0;
        w_retire     = 1'b0;
        w_drive      = 1'b0;
        w_we         = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_pc_clr     = 1'b1;
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                w_ir_load    = 1'b1;
                w_state_next = StDecode;
            end
            StDecode: begin
                // HALT ends the run without a write or retire
                if (r_ir == HALT_OPCODE) begin
                    w_state_next = StDone;
                end else begin
                    w_drive      = 1'b1;
                    w_state_next = StExecute;
                end
            end
            StExecute: begin
                w_drive      = 1'b1;
                w_state_next = StWriteback;
            end
            StWriteback: begin
                w_drive  = 1'b1;
                w_we     = 1'b1;
                w_retire = 1'b1;
                if (w_count_inc == PROG_LEN_C) begin
                    w_state_next = StDone;
                end else begin
                    w_pc_inc = 1'b1;
`ifdef SEQ_STEP_EN
                    w_state_next = StStepWait;
`else
                    w_state_next = StFetch;
`endif
                end
            end
`ifdef SEQ_STEP_EN
            StStepWait: begin
                if (step) begin
                    w_state_next = StFetch;
                end
            end
`endif
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_ir_load) begin
                r_ir <= imem_data;
            end
            if (w_pc_clr) begin
                r_count <= '0;
            end else if (w_retire) begin
                r_count <= w_count_inc;
            end
        end
    end

    seq_pc #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .PC_WIDTH   (PC_WIDTH)
    ) u_seq_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_pc_clr),
        .i_inc   (w_pc_inc),
        .o_pc    (imem_addr)
    );

    // Outputs decode straight from state so reset forces them all low at once
    assign busy        = (r_state != StIdle);
    assign done        = (r_state == StDone);
    assign rf_we       = w_we;
    assign rf_rd_sel   = w_drive ? r_ir[RD_LSB +: FIELD_W]  : 2'b00;
    assign rf_rs1_sel  = w_drive ? r_ir[RS1_LSB +: FIELD_W] : 2'b00;
    assign rf_rs2_sel  = w_drive ? r_ir[RS2_LSB +: FIELD_W] : 2'b00;
    assign alu_op      = w_drive ? w_alu_op                 : AluAdd;
    assign instr_count = r_count;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed bench for exec_sequencer.
// Instance A runs PROG_LEN=3, instance B runs PROG_LEN=IMEM_DEPTH=64.
// Inputs change and outputs are sampled on the falling edge; "cycle n" is the
// interval following the n-th rising edge after the start-accept edge (edge 0).
module tb_exec_sequencer;

    logic       clk;
    logic       reset_n;

    logic       start_a, start_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic [5:0] imem_addr_a, imem_addr_b;
    logic [7:0] imem_data_a, imem_data_b;
    logic [1:0] rd_a, rs1_a, rs2_a, op_a;
    logic [1:0] rd_b, rs1_b, rs2_b, op_b;
    logic       we_a, we_b;
    logic [6:0] cnt_a, cnt_b;
`ifdef SEQ_STEP_EN
    logic       step_a, step_b;
`endif

    logic [7:0] rom_a [64];
    logic [7:0] rom_b [64];

    int n_assert;
    int n_fail;

    assign imem_data_a = rom_a[imem_addr_a];
    assign imem_data_b = rom_b[imem_addr_b];

    exec_sequencer #(
        .IMEM_DEPTH (64),
        .PROG_LEN   (3)
    ) u_dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start_a),
`ifdef SEQ_STEP_EN
        .step        (step_a),
`endif
        .busy        (busy_a),
        .done        (done_a),
        .imem_addr   (imem_addr_a),
        .imem_data   (imem_data_a),
        .rf_rd_sel   (rd_a),
        .rf_rs1_sel  (rs1_a),
        .rf_rs2_sel  (rs2_a),
        .rf_we       (we_a),
        .alu_op      (op_a),
        .instr_count (cnt_a)
    );

    exec_sequencer #(
        .IMEM_DEPTH (64),
        .PROG_LEN   (64)
    ) u_dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start_b),
`ifdef SEQ_STEP_EN
        .step        (step_b),
`endif
        .busy        (busy_b),
        .done        (done_b),
        .imem_addr   (imem_addr_b),
        .imem_data   (imem_data_b),
        .rf_rd_sel   (rd_b),
        .rf_rs1_sel  (rs1_b),
        .rf_rs2_sel  (rs2_b),
        .rf_we       (we_b),
        .alu_op      (op_b),
        .instr_count (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected $finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_prog(input logic [7:0] i0, input logic [7:0] i1, input logic [7:0] i2);
        for (int i = 0; i < 64; i++) rom_a[i] = 8'h00;
        rom_a[0] = i0;
        rom_a[1] = i1;
        rom_a[2] = i2;
    endtask

    // Pulse start_a for one cycle; returns at cycle 1 of the run
    task automatic accept_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_busy"}, 32'(busy_a), 32'(0));
        check({tag, "_done"}, 32'(done_a), 32'(0));
        check({tag, "_we"},   32'(we_a),   32'(0));
        check({tag, "_sel"},  32'({rd_a, rs1_a, rs2_a, op_a}), 32'(0));
    endtask

    initial begin
        logic [1:0] exp_rd  [3];
        logic [1:0] exp_rs1 [3];
        logic [1:0] exp_rs2 [3];
        logic [1:0] exp_op  [3];
        int we_cnt, done_cnt, busy_cnt, consec, t, max_addr, refetch;
        logic prev_we;

        // 8'h1B, 8'h66, 8'hC1 decoded by hand
        exp_rd  = '{2'd0, 2'd1, 2'd3};
        exp_rs1 = '{2'd1, 2'd2, 2'd0};
        exp_rs2 = '{2'd2, 2'd1, 2'd0};
        exp_op  = '{2'd3, 2'd2, 2'd1};

        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
`ifdef SEQ_STEP_EN
        step_a   = 1'b0;
        step_b   = 1'b0;
`endif
        load_prog(8'h1B, 8'h66, 8'hC1);
        for (int i = 0; i < 64; i++) rom_b[i] = 8'h00;

        repeat (3) @(negedge clk);
        check_idle_a("rst");
        check("rst_addr", 32'(imem_addr_a), 32'(0));
        check("rst_cnt",  32'(cnt_a),       32'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_a("idle");

`ifdef SEQ_STEP_EN
        // Single-step: hold in step-wait after the first writeback
        accept_a();
        repeat (3) @(negedge clk);
        check("st_we4", 32'(we_a), 32'(1));
        busy_cnt = 0; we_cnt = 0; consec = 0;
        for (int c = 5; c <= 14; c++) begin
            @(negedge clk);
            if (busy_a) busy_cnt++;
            if (we_a) we_cnt++;
            if (rd_a != 2'd0 || rs1_a != 2'd0 || rs2_a != 2'd0 || op_a != 2'd0) consec++;
        end
        check("st_busy_hold", 32'(busy_cnt), 32'(10));
        check("st_we_hold",   32'(we_cnt),   32'(0));
        check("st_sel_hold",  32'(consec),   32'(0));
        step_a = 1'b1;
        @(negedge clk);
        check("st_fetch_addr", 32'(imem_addr_a), 32'(1));
        check("st_fetch_busy", 32'(busy_a),      32'(1));
        t = 0;
        while (!done_a && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("st_done_seen", 32'(done_a), 32'(1));
        step_a = 1'b0;
        @(negedge clk);
        check("st_cnt", 32'(cnt_a), 32'(3));
`else
        // Test 1: three-instruction run
        accept_a();
        for (int c = 1; c <= 13; c++) begin
            check($sformatf("t1_we_c%0d", c),   32'(we_a),   32'(c % 4 == 0));
            check($sformatf("t1_done_c%0d", c), 32'(done_a), 32'(c == 13));
            check($sformatf("t1_busy_c%0d", c), 32'(busy_a), 32'(1));
            if (c % 4 == 0) begin
                check($sformatf("t1_rd_c%0d", c),  32'(rd_a),  32'(exp_rd[c/4-1]));
                check($sformatf("t1_rs1_c%0d", c), 32'(rs1_a), 32'(exp_rs1[c/4-1]));
                check($sformatf("t1_rs2_c%0d", c), 32'(rs2_a), 32'(exp_rs2[c/4-1]));
                check($sformatf("t1_op_c%0d", c),  32'(op_a),  32'(exp_op[c/4-1]));
            end
            if (c % 4 == 1) begin
                check($sformatf("t1_fsel_c%0d", c), 32'({rd_a, op_a}), 32'(0));
                if (c < 13) check($sformatf("t1_addr_c%0d", c), 32'(imem_addr_a), 32'(c / 4));
            end
            if (c < 13) @(negedge clk);
        end
        @(negedge clk);
        check_idle_a("t1_end");
        check("t1_cnt",  32'(cnt_a),       32'(3));
        check("t1_addr", 32'(imem_addr_a), 32'(2));

        // Test 2: HALT at index 1
        load_prog(8'h05, 8'hFF, 8'h05);
        accept_a();
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("t2_we_c%0d", c),   32'(we_a),   32'(c == 4));
            check($sformatf("t2_done_c%0d", c), 32'(done_a), 32'(c == 7));
            if (c < 7) @(negedge clk);
        end
        @(negedge clk);
        check_idle_a("t2_end");
        check("t2_cnt",  32'(cnt_a),       32'(1));
        check("t2_addr", 32'(imem_addr_a), 32'(1));

        // Test 3: start held for 20 cycles
        load_prog(8'h1B, 8'h66, 8'hC1);
        start_a = 1'b1;
        we_cnt = 0; done_cnt = 0; consec = 0; prev_we = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (we_a) we_cnt++;
            if (we_a && prev_we) consec++;
            prev_we = we_a;
            if (c <= 13 && done_a) done_cnt++;
            if (c == 14) begin
                check("t3_idle_busy", 32'(busy_a),      32'(0));
                check("t3_idle_addr", 32'(imem_addr_a), 32'(2));
            end
            if (c == 15) begin
                check("t3_rerun_busy", 32'(busy_a),      32'(1));
                check("t3_rerun_addr", 32'(imem_addr_a), 32'(0));
                check("t3_rerun_cnt",  32'(cnt_a),       32'(0));
            end
        end
        start_a = 1'b0;
        check("t3_done_cnt",   32'(done_cnt), 32'(1));
        check("t3_we_cnt",     32'(we_cnt),   32'(4));
        check("t3_we_consec",  32'(consec),   32'(0));
        t = 20;
        while (!done_a && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("t3_done2_cycle", 32'(t), 32'(27));
        @(negedge clk);

        // Test 4: reset during EXECUTE of instruction 1
        accept_a();
        repeat (6) @(negedge clk);
        check("t4_ex_rd", 32'(rd_a), 32'(1));
        check("t4_ex_op", 32'(op_a), 32'(2));
        #2 reset_n = 1'b0;
        #1;
        check_idle_a("t4_rst");
        check("t4_rst_addr", 32'(imem_addr_a), 32'(0));
        check("t4_rst_cnt",  32'(cnt_a),       32'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        we_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (we_a) we_cnt++;
            if (busy_a) busy_cnt++;
        end
        check("t4_post_we",   32'(we_cnt),   32'(0));
        check("t4_post_busy", 32'(busy_cnt), 32'(0));
        accept_a();
        check("t4_restart_addr", 32'(imem_addr_a), 32'(0));
        repeat (3) @(negedge clk);
        check("t4_restart_rd", 32'(rd_a), 32'(0));
        repeat (9) @(negedge clk);
        check("t4_restart_done", 32'(done_a), 32'(1));
        @(negedge clk);
        check("t4_restart_cnt", 32'(cnt_a), 32'(3));

        // Test 5: PROG_LEN == IMEM_DEPTH on instance B
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        t = 1; we_cnt = 0; max_addr = 0; refetch = 0;
        while (!done_b && t < 300) begin
            if (we_b) we_cnt++;
            if (int'(imem_addr_b) > max_addr) max_addr = int'(imem_addr_b);
            if (t > 4 && imem_addr_b == 6'd0) refetch++;
            @(negedge clk);
            t++;
        end
        check("t5_done_cycle", 32'(t),        32'(257));
        check("t5_we_cnt",     32'(we_cnt),   32'(64));
        check("t5_max_addr",   32'(max_addr), 32'(63));
        check("t5_refetch",    32'(refetch),  32'(0));
        @(negedge clk);
        check("t5_cnt",  32'(cnt_b),  32'(64));
        check("t5_busy", 32'(busy_b), 32'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
